// File: rtl/clock_divider_pkg.sv
// Shared constants and types for the programmable clock divider.
package clock_divider_pkg;

  localparam int DEF_CNT_W = 8;   // default counter width
  localparam int MIN_DIV   = 2;   // smallest usable divide ratio
  localparam int DEF_DIV   = 8;   // divide ratio after reset
  localparam int DEF_HIGH  = 4;   // high time after reset

  // Channel run state. CH_INIT covers the single edge after reset release,
  // where the channel picks up its reset-time run state.
  typedef enum logic [1:0] {
    CH_INIT = 2'd0,
    CH_STOP = 2'd1,
    CH_RUN  = 2'd2
  } ch_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: period counter, shadow config with pending flag,
// commit-at-wrap logic and registered clk_out/tick outputs.
module clock_div_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH,
  parameter bit RESET_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  input  logic             wr_en,
  input  logic             restart,
  output logic             pending,
  output logic             clk_out,
  output logic             tick,
  output logic             active
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);

  ch_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic [CNT_W-1:0] sh_div_reg, sh_div_next;
  logic [CNT_W-1:0] sh_high_reg, sh_high_next;
  logic             sh_en_reg, sh_en_next;
  logic             pending_reg, pending_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;

  logic             accept;
  logic [CNT_W-1:0] src_div, src_div_clamped, src_high;
  logic             src_en;
  ch_state_t        reset_run_state, src_run_state;

  // Config source for a commit: a write landing on this edge wins over the shadow.
  always_comb begin
    accept          = wr && !pending_reg;
    src_div         = accept ? wr_div  : sh_div_reg;
    src_high        = accept ? wr_high : sh_high_reg;
    src_en          = accept ? wr_en   : sh_en_reg;
    src_div_clamped = (src_div < MIN_D) ? MIN_D : src_div;
    src_run_state   = src_en ? CH_RUN : CH_STOP;
    reset_run_state = RESET_EN ? CH_RUN : CH_STOP;
  end

  // Next-state: restart beats wrap; running channels commit only at wrap,
  // stopped channels commit on the edge after acceptance.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_next     = div_reg;
    high_next    = high_reg;
    sh_div_next  = sh_div_reg;
    sh_high_next = sh_high_reg;
    sh_en_next   = sh_en_reg;
    pending_next = pending_reg;

    if (accept) begin
      sh_div_next  = wr_div;
      sh_high_next = wr_high;
      sh_en_next   = wr_en;
      pending_next = 1'b1;
    end

    if (restart) begin
      cnt_next = '0;
      if (pending_reg || accept) begin
        div_next     = src_div_clamped;
        high_next    = src_high;
        state_next   = src_run_state;
        pending_next = 1'b0;
      end else if (state_reg == CH_INIT) begin
        state_next = reset_run_state;
      end
    end else begin
      case (state_reg)
        CH_INIT: begin
          state_next = reset_run_state;
          cnt_next   = '0;
        end
        CH_RUN: begin
          if (cnt_reg >= div_reg - ONE) begin
            cnt_next = '0;
            if (pending_reg) begin
              div_next     = src_div_clamped;
              high_next    = src_high;
              state_next   = src_run_state;
              pending_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end
        CH_STOP: begin
          if (pending_reg) begin
            div_next     = src_div_clamped;
            high_next    = src_high;
            state_next   = src_run_state;
            cnt_next     = '0;
            pending_next = 1'b0;
          end
        end
        default: state_next = CH_INIT;
      endcase
    end

    clk_out_next = (state_next == CH_RUN) && (cnt_next < high_next);
    tick_next    = (state_next == CH_RUN) && (cnt_next == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= CH_INIT;
      cnt_reg     <= '0;
      div_reg     <= CNT_W'(DEFAULT_DIV);
      high_reg    <= CNT_W'(DEFAULT_HIGH);
      sh_div_reg  <= CNT_W'(DEFAULT_DIV);
      sh_high_reg <= CNT_W'(DEFAULT_HIGH);
      sh_en_reg   <= 1'b0;
      pending_reg <= 1'b0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_reg     <= div_next;
      high_reg    <= high_next;
      sh_div_reg  <= sh_div_next;
      sh_high_reg <= sh_high_next;
      sh_en_reg   <= sh_en_next;
      pending_reg <= pending_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
    end
  end

  assign pending = pending_reg;
  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign active  = (state_reg == CH_RUN);

endmodule

// File: rtl/clock_divider.sv
// N_CH-channel programmable clock divider: decodes the config port into
// per-channel write strobes and reports per-channel readiness.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH,
  parameter bit RESET_EN     = 1'b1,
  localparam int CH_W        = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_en,
  input  logic             sync_restart,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  active
);

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] wr_strobe;

  // Ready unless the index is out of range or that channel already holds a config.
  always_comb begin
    cfg_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign wr_strobe[gi] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));

      clock_div_channel #(
        .CNT_W        (CNT_W),
        .DEFAULT_DIV  (DEFAULT_DIV),
        .DEFAULT_HIGH (DEFAULT_HIGH),
        .RESET_EN     (RESET_EN)
      ) u_ch (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr_strobe[gi]),
        .wr_div  (cfg_div),
        .wr_high (cfg_high),
        .wr_en   (cfg_en),
        .restart (sync_restart),
        .pending (pending[gi]),
        .clk_out (clk_out[gi]),
        .tick    (tick[gi]),
        .active  (active[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: directed table, corner sequences and
// randomized traffic against a period-arithmetic reference model.
module tb_clock_divider;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [1:0]   cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_en = 1'b0;
  logic         sync_restart = 1'b0;
  logic [N-1:0] clk_out, tick, active;

  clock_divider #(.N_CH(N), .CNT_W(W), .DEFAULT_DIV(8), .DEFAULT_HIGH(4), .RESET_EN(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .cfg_en       (cfg_en),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick),
    .active       (active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the period, current and shadow settings.
  int m_pos[N], m_div[N], m_high[N], sh_div[N], sh_high[N];
  bit m_act[N], m_pend[N], sh_en[N];
  bit m_started;

  typedef struct {
    int ch; int div; int high; int en;
    int exp_period; int exp_high;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int clamp_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_pos[c] = 0; m_div[c] = 8; m_high[c] = 4; m_act[c] = 0; m_pend[c] = 0;
      sh_div[c] = 8; sh_high[c] = 4; sh_en[c] = 0;
    end
    m_started = 0;
  endtask

  task automatic apply_shadow(input int c);
    m_div[c]  = clamp_div(sh_div[c]);
    m_high[c] = sh_high[c];
    m_act[c]  = sh_en[c];
    m_pend[c] = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented on it.
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit acc;
      acc = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
      if (acc) begin
        sh_div[c] = int'(cfg_div); sh_high[c] = int'(cfg_high); sh_en[c] = cfg_en;
        m_pend[c] = 1;
      end
      if (sync_restart) begin
        m_pos[c] = 0;
        if (m_pend[c]) apply_shadow(c);
        else if (!m_started) m_act[c] = 1;
      end else if (!m_started) begin
        m_act[c] = 1;
        m_pos[c] = 0;
      end else if (m_act[c]) begin
        m_pos[c] = (m_pos[c] + 1) % m_div[c];
        // A fresh acceptance on this edge waits for the following wrap.
        if (m_pos[c] == 0 && m_pend[c] && !acc) apply_shadow(c);
      end else if (m_pend[c] && !acc) begin
        apply_shadow(c);
        m_pos[c] = 0;
      end
    end
    m_started = 1;
  endtask

  // One clock: check ready, let the edge happen, compare outputs on the falling edge.
  task automatic step();
    logic [N-1:0] ec, et, ea;
    #1;
    chk("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      ea[c] = m_act[c];
      ec[c] = m_act[c] && (m_pos[c] < m_high[c]);
      et[c] = m_act[c] && (m_pos[c] == 0);
    end
    chk("clk_out", clk_out, ec);
    chk("tick", tick, et);
    chk("active", active, ea);
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi, input bit en);
    bit acc;
    cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = W'(dv); cfg_high = W'(hi); cfg_en = en;
    acc = !m_pend[ch];
    step();
    cfg_valid = 0;
    $display("cfg write ch=%0d div=%0d high=%0d en=%0d accepted=%0d", ch, dv, hi, en, acc);
  endtask

  task automatic wait_commit(input int ch);
    for (int i = 0; i < 100 && m_pend[ch]; i++) step();
  endtask

  // Starting on a tick cycle, measure the period and high time of one channel.
  task automatic count_period(input int ch, input int exp_p, input int exp_h, input string tag);
    int n, h;
    n = 1; h = int'(clk_out[ch]);
    step();
    while (!tick[ch] && n < 300) begin
      h += int'(clk_out[ch]);
      n++;
      step();
    end
    chk({tag, "_period"}, n, exp_p);
    chk({tag, "_high"}, h, exp_h);
    $display("measure %s ch=%0d period=%0d high=%0d", tag, ch, n, h);
  endtask

  // Default settings: each clk_out reads 11110000, tick every 8 starting at the first edge.
  task automatic pattern_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      chk({tag, "_clk0"}, clk_out[0], (i % 8) < 4);
      chk({tag, "_tick0"}, tick[0], (i % 8) == 0);
      if (i == 0) chk({tag, "_active"}, active, 4'hF);
    end
  endtask

  initial begin
    vecs[0] = '{ch: 2, div: 1,  high: 0,  en: 1, exp_period: 2,  exp_high: 0};
    vecs[1] = '{ch: 2, div: 5,  high: 9,  en: 1, exp_period: 5,  exp_high: 5};
    vecs[2] = '{ch: 0, div: 0,  high: 3,  en: 1, exp_period: 2,  exp_high: 2};
    vecs[3] = '{ch: 3, div: 16, high: 16, en: 1, exp_period: 16, exp_high: 16};
    vecs[4] = '{ch: 1, div: 7,  high: 0,  en: 1, exp_period: 7,  exp_high: 0};
    vecs[5] = '{ch: 0, div: 4,  high: 1,  en: 1, exp_period: 4,  exp_high: 1};

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_clk_out", clk_out, 0);
    chk("reset_tick", tick, 0);
    chk("reset_active", active, 0);
    reset_n = 1;
    pattern_check("defaults");

    // ch1 rewritten mid-period; a second write is held off until commit
    for (int i = 0; i < 20 && m_pos[1] != 2; i++) step();
    cfg_write(1, 3, 1, 1);
    cfg_ch = 2'd1;
    #1 chk("ready_held", cfg_ready, 0);
    cfg_write(1, 6, 2, 1);
    wait_commit(1);
    chk("ch1_commit_tick", tick[1], 1);
    count_period(1, 3, 1, "ch1_div3");

    // Directed table
    foreach (vecs[k]) begin
      cfg_write(vecs[k].ch, vecs[k].div, vecs[k].high, vecs[k].en[0]);
      wait_commit(vecs[k].ch);
      chk("vec_commit_tick", tick[vecs[k].ch], 1);
      count_period(vecs[k].ch, vecs[k].exp_period, vecs[k].exp_high, "vec");
    end

    // ch0 disable mid-period, then re-enable
    step();
    cfg_write(0, 8, 4, 0);
    wait_commit(0);
    chk("dis_active0", active[0], 0);
    chk("dis_clk0", clk_out[0], 0);
    repeat (3) step();
    chk("dis_still_off", active[0], 0);
    cfg_write(0, 8, 4, 1);
    chk("reen_wait", tick[0], 0);
    step();
    chk("reen_tick", tick[0], 1);

    // sync_restart with a pending write on ch3
    repeat (3) step();
    cfg_write(3, 5, 2, 1);
    sync_restart = 1;
    step();
    sync_restart = 0;
    $display("sync_restart issued");
    chk("restart_ticks", tick, 4'hF);
    count_period(3, 5, 2, "ch3_restart");

    // Asynchronous reset between edges while clk_out is high
    for (int i = 0; i < 20 && !clk_out[0]; i++) step();
    @(posedge clk);
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("async_clk_out", clk_out, 0);
    chk("async_tick", tick, 0);
    chk("async_active", active, 0);
    repeat (2) @(negedge clk);
    chk("async_hold", clk_out | tick | active, 0);
    reset_n = 1;
    pattern_check("after_reset");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cfg_valid    = ($urandom_range(0, 3) == 0);
      cfg_ch       = 2'($urandom_range(0, 3));
      cfg_div      = W'($urandom_range(0, 12));
      cfg_high     = W'($urandom_range(0, 14));
      cfg_en       = ($urandom_range(0, 3) != 0);
      sync_restart = ($urandom_range(0, 39) == 0);
      if (cfg_valid && !m_pend[cfg_ch])
        $display("rand cfg ch=%0d div=%0d high=%0d en=%0d restart=%0d",
                 cfg_ch, cfg_div, cfg_high, cfg_en, sync_restart);
      step();
    end
    cfg_valid = 0;
    sync_restart = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
